// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
package inst_fetch_ctrl_pkg;
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  localparam int          INST_BYTES   = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-to-decode handshake: one instruction word per valid/ready transfer.
interface inst_fetch_ctrl_if #(
  parameter int AW = 32,
  parameter int IW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_inst;
  logic          out_fault;

  modport master (output out_valid, out_pc, out_inst, out_fault, input out_ready);
  modport slave  (input out_valid, out_pc, out_inst, out_fault, output out_ready);
endinterface

// File: rtl/inst_fetch_ctrl_skid_fifo.sv
// Two-entry skid FIFO holding captured fetch words; flush wins over push/pop.
module fetch_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr;

  assign wr_ptr = rd_ptr_q ^ count_q[0];
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (push) mem_d[wr_ptr] = push_data;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && count_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && count_q == 2'd0));
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues reads to a 1-cycle inst_mem,
// and hands words to decode through a 2-entry skid buffer with redirect/fault handling.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            IW       = 32,
  parameter int            DEPTH    = 16,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [AW-1:0]      redirect_pc,
  output logic [AW-1:0]      mem_raddr,
  input  logic [IW-1:0]      mem_inst,
  inst_fetch_ctrl_if.master  dec,
  output logic               busy
);
  localparam int            W       = AW + IW + 1;
  localparam logic [AW-1:0] HI_MASK = {AW{1'b1}} << (DEPTH + 2);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] issued_pc_q, issued_pc_d;
  logic          issued_bad_q, issued_bad_d;
  logic          inflight_q, inflight_d;
  logic          squash_q, squash_d;

  logic [1:0]    count;
  logic [2:0]    occ;
  logic          bad, issue, capture, out_valid, pop, fifo_push, fifo_pop;
  logic [IW-1:0] cap_inst;
  logic [W-1:0]  cap_word, fifo_head, head;

  assign mem_raddr = fetch_pc_q;
  assign bad       = (fetch_pc_q[1:0] != 2'b00) | ((fetch_pc_q & HI_MASK) != '0);

  // The returning word is presented straight from inst_mem when the buffer is
  // empty, so a streaming consumer sees one word per cycle with no extra stage.
  assign capture   = inflight_q & ~squash_q;
  assign cap_inst  = issued_bad_q ? '0 : mem_inst;
  assign cap_word  = {issued_pc_q, cap_inst, issued_bad_q};
  assign head      = (count != 2'd0) ? fifo_head : cap_word;
  assign out_valid = (count != 2'd0) | capture;
  assign pop       = out_valid & dec.out_ready;
  assign fifo_pop  = pop & (count != 2'd0);
  assign fifo_push = capture & ~redirect_valid & ~(pop & (count == 2'd0));

  assign occ   = {1'b0, count} + {2'b00, inflight_q};
  // A faulting word in flight blocks further issue until it reaches the buffer.
  assign issue = (state_q == FETCH_RUN) & ~redirect_valid & ~(inflight_q & issued_bad_q)
               & (occ < (3'd2 + {2'b00, pop}));

  assign dec.out_valid = out_valid;
  assign {dec.out_pc, dec.out_inst, dec.out_fault} = out_valid ? head : '0;
  assign busy = (state_q != FETCH_IDLE) | (count != 2'd0) | inflight_q;

  fetch_skid_fifo #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (cap_word),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (fifo_head)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    issued_pc_d  = issued_pc_q;
    issued_bad_d = issued_bad_q;
    inflight_d   = 1'b0;
    squash_d     = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      squash_d   = inflight_q;
      if (state_q == FETCH_FAULT) state_d = fetch_en ? FETCH_RUN : FETCH_IDLE;
    end else begin
      if (issue) begin
        inflight_d   = 1'b1;
        issued_pc_d  = fetch_pc_q;
        issued_bad_d = bad;
        if (!bad) fetch_pc_d = fetch_pc_q + AW'(INST_BYTES);
      end
      if (capture && issued_bad_q) begin
        state_d = FETCH_FAULT;
      end else begin
        case (state_q)
          FETCH_IDLE: if (fetch_en)  state_d = FETCH_RUN;
          FETCH_RUN:  if (!fetch_en) state_d = FETCH_IDLE;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      fetch_pc_q   <= RESET_PC;
      issued_pc_q  <= '0;
      issued_bad_q <= 1'b0;
      inflight_q   <= 1'b0;
      squash_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      issued_pc_q  <= issued_pc_d;
      issued_bad_q <= issued_bad_d;
      inflight_q   <= inflight_d;
      squash_q     <= squash_d;
    end
  end
endmodule
